// File: rtl/ni_output_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : ni_output_arbiter_if
// Description : Handshake bundle between the PE-side packet sources and the
//               router local injection port, as seen by ni_output_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface ni_output_arbiter_if #(
  parameter int ROUTER_WIDTH = 36
);
  // Control pulses
  logic                    pe_start_calc;
  logic                    downstream_credit;

  // Read-response source
  logic                    rd_rsp_valid;
  logic [ROUTER_WIDTH-1:0] rd_rsp_pkt;
  logic                    rd_rsp_ready;

  // Output-activation source
  logic                    oact_valid;
  logic [ROUTER_WIDTH-1:0] oact_pkt;
  logic                    oact_ready;

  // PE-done source
  logic                    fin_valid;
  logic [ROUTER_WIDTH-1:0] fin_pkt;
  logic                    fin_ready;

  // Router side
  logic                    out_data_valid;
  logic [ROUTER_WIDTH-1:0] out_data;
  logic                    credit_err;

  // Arbiter view
  modport slave (
    input  pe_start_calc, downstream_credit,
    input  rd_rsp_valid, rd_rsp_pkt,
    output rd_rsp_ready,
    input  oact_valid, oact_pkt,
    output oact_ready,
    input  fin_valid, fin_pkt,
    output fin_ready,
    output out_data_valid, out_data, credit_err
  );

  // Source / router-model view
  modport master (
    output pe_start_calc, downstream_credit,
    output rd_rsp_valid, rd_rsp_pkt,
    input  rd_rsp_ready,
    output oact_valid, oact_pkt,
    input  oact_ready,
    output fin_valid, fin_pkt,
    input  fin_ready,
    input  out_data_valid, out_data, credit_err
  );
endinterface
`default_nettype wire

// File: rtl/ni_output_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ni_output_arbiter
// Description : Credit-based injection arbiter sharing the router local input
//               port between read responses, output activations and the
//               one-shot PE-done packet. Done always follows the last result.
// Revision    : 1.0 - initial release
// ============================================================================
module ni_output_arbiter #(
  parameter int CREDIT_DEPTH = 4,
  parameter int CW           = 3,
  parameter int ROUTER_WIDTH = 36
) (
  input  logic                clk,
  input  logic                rst,   // asynchronous, active low
  ni_output_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [CW-1:0] C_CREDIT_INIT = CW'(CREDIT_DEPTH);
  localparam logic [CW-1:0] C_ONE         = CW'(1);

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    last_oact_q, last_oact_d;   // 1: oact won last tie-break
  logic                    credit_err_q, credit_err_d;
  logic                    out_valid_q;
  logic [ROUTER_WIDTH-1:0] out_data_q, out_data_d;

  logic                    w_has_credit;
  logic                    w_oact_req;
  logic                    w_gnt_rd, w_gnt_oact, w_gnt_fin, w_gnt_any;

  // Single-winner grant: registered credit only, rd/oact round-robin, fin
  // only once both result sources are idle while draining.
  always_comb begin
    w_gnt_rd     = 1'b0;
    w_gnt_oact   = 1'b0;
    w_gnt_fin    = 1'b0;
    w_has_credit = (cnt_q != '0);
    w_oact_req   = bus.oact_valid && (state_q != ST_DONE);
    if (w_has_credit) begin
      if (bus.rd_rsp_valid && w_oact_req) begin
        if (last_oact_q) w_gnt_rd   = 1'b1;
        else             w_gnt_oact = 1'b1;
      end else if (bus.rd_rsp_valid) begin
        w_gnt_rd = 1'b1;
      end else if (w_oact_req) begin
        w_gnt_oact = 1'b1;
      end else if ((state_q == ST_DRAIN) && bus.fin_valid) begin
        w_gnt_fin = 1'b1;
      end
    end
    w_gnt_any = w_gnt_rd | w_gnt_oact | w_gnt_fin;
  end

  // Readies are the grants, forced low while reset is held
  assign bus.rd_rsp_ready = w_gnt_rd   & rst;
  assign bus.oact_ready   = w_gnt_oact & rst;
  assign bus.fin_ready    = w_gnt_fin  & rst;

  // Phase sequencing: RUN -> DRAIN on done request, DRAIN -> DONE on fin grant
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:   if (bus.fin_valid)     state_d = ST_DRAIN;
      ST_DRAIN: if (w_gnt_fin)         state_d = ST_DONE;
      ST_DONE:  if (bus.pe_start_calc) state_d = ST_RUN;
      default:                         state_d = ST_RUN;
    endcase
  end

  // Credit bookkeeping, round-robin pointer and packet capture
  always_comb begin
    cnt_d        = cnt_q;
    credit_err_d = credit_err_q;
    last_oact_d  = last_oact_q;
    out_data_d   = out_data_q;
    if (w_gnt_any && !bus.downstream_credit) begin
      cnt_d = cnt_q - C_ONE;
    end else if (!w_gnt_any && bus.downstream_credit) begin
      // A credit beyond the FIFO depth is a protocol error; keep the count
      if (cnt_q >= C_CREDIT_INIT) credit_err_d = 1'b1;
      else                        cnt_d        = cnt_q + C_ONE;
    end
    if (w_gnt_rd)   last_oact_d = 1'b0;
    if (w_gnt_oact) last_oact_d = 1'b1;
    if (w_gnt_rd)        out_data_d = bus.rd_rsp_pkt;
    else if (w_gnt_oact) out_data_d = bus.oact_pkt;
    else if (w_gnt_fin)  out_data_d = bus.fin_pkt;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_RUN;
    else      state_q <= state_d;
  end

  // Datapath and bookkeeping registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q        <= C_CREDIT_INIT;
      last_oact_q  <= 1'b1;
      credit_err_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
    end else begin
      cnt_q        <= cnt_d;
      last_oact_q  <= last_oact_d;
      credit_err_q <= credit_err_d;
      out_valid_q  <= w_gnt_any;
      out_data_q   <= out_data_d;
    end
  end

  assign bus.out_data_valid = out_valid_q;
  assign bus.out_data       = out_data_q;
  assign bus.credit_err     = credit_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ni_output_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ni_output_arbiter
// Description : Self-checking bench for ni_output_arbiter: directed vector
//               table, hand sequences for DONE / async reset, random traffic
//               against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ni_output_arbiter;
  localparam int RW    = 36;
  localparam int DEPTH = 4;

  localparam int G_NONE = 0, G_RD = 1, G_OA = 2, G_FIN = 3;
  localparam int PH_RUN = 0, PH_DRAIN = 1, PH_DONE = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ni_output_arbiter_if #(.ROUTER_WIDTH(RW)) bus ();

  ni_output_arbiter #(.CREDIT_DEPTH(DEPTH), .CW(3), .ROUTER_WIDTH(RW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural reference: free FIFO slots, phase, last tie winner
  int          m_cred;
  int          m_phase;
  bit          m_last_oact;
  bit          m_err;
  bit          m_ov;
  logic [RW-1:0] m_od;

  typedef struct {
    bit rd; bit oa; bit fin; bit st; bit cr;
    int exp_g;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t v(bit rd, bit oa, bit fin, bit st, bit cr, int g);
    vec_t r;
    r.rd = rd; r.oa = oa; r.fin = fin; r.st = st; r.cr = cr; r.exp_g = g;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cred = DEPTH; m_phase = PH_RUN; m_last_oact = 1'b1;
    m_err = 1'b0; m_ov = 1'b0; m_od = '0;
  endtask

  function automatic int model_grant(bit rd, bit oa, bit fin);
    bit oa_ok;
    oa_ok = oa && (m_phase != PH_DONE);
    if (m_cred == 0)       return G_NONE;
    if (rd && oa_ok)       return m_last_oact ? G_RD : G_OA;
    if (rd)                return G_RD;
    if (oa_ok)             return G_OA;
    if (m_phase == PH_DRAIN && fin) return G_FIN;
    return G_NONE;
  endfunction

  task automatic model_update(input int g, input bit cr, input bit st, input bit fin,
                              input logic [RW-1:0] prd, input logic [RW-1:0] poa,
                              input logic [RW-1:0] pfin);
    m_ov = (g != G_NONE);
    if (g == G_RD)  begin m_od = prd;  m_last_oact = 1'b0; end
    if (g == G_OA)  begin m_od = poa;  m_last_oact = 1'b1; end
    if (g == G_FIN) m_od = pfin;
    if (cr && g == G_NONE && m_cred == DEPTH) m_err = 1'b1;
    else m_cred = m_cred + (cr ? 1 : 0) - ((g != G_NONE) ? 1 : 0);
    case (m_phase)
      PH_RUN:   if (fin)        m_phase = PH_DRAIN;
      PH_DRAIN: if (g == G_FIN) m_phase = PH_DONE;
      default:  if (st)         m_phase = PH_RUN;
    endcase
  endtask

  // One clock cycle: drive, check against model at negedge, advance model
  task automatic cyc(input bit rd, input bit oa, input bit fin, input bit st, input bit cr,
                     input logic [RW-1:0] prd, input logic [RW-1:0] poa,
                     input logic [RW-1:0] pfin, output int g_dut);
    int g_m;
    bus.rd_rsp_valid = rd; bus.oact_valid = oa; bus.fin_valid = fin;
    bus.pe_start_calc = st; bus.downstream_credit = cr;
    bus.rd_rsp_pkt = prd; bus.oact_pkt = poa; bus.fin_pkt = pfin;
    @(negedge clk);
    g_m = model_grant(rd, oa, fin);
    chk("rd_rsp_ready", bus.rd_rsp_ready, g_m == G_RD);
    chk("oact_ready",   bus.oact_ready,   g_m == G_OA);
    chk("fin_ready",    bus.fin_ready,    g_m == G_FIN);
    chk("out_data_valid", bus.out_data_valid, m_ov);
    chk("out_data",     bus.out_data,     m_od);
    chk("credit_err",   bus.credit_err,   m_err);
    g_dut = bus.rd_rsp_ready ? G_RD : bus.oact_ready ? G_OA : bus.fin_ready ? G_FIN : G_NONE;
    model_update(g_m, cr, st, fin, prd, poa, pfin);
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    bus.rd_rsp_valid = 0; bus.oact_valid = 0; bus.fin_valid = 0;
    bus.pe_start_calc = 0; bus.downstream_credit = 0;
    bus.rd_rsp_pkt = '0; bus.oact_pkt = '0; bus.fin_pkt = '0;
  endtask

  // Reset with a pending request to confirm readies stay low during reset
  task automatic do_reset();
    idle_inputs();
    bus.rd_rsp_valid = 1'b1;
    rst = 1'b0;
    #1;
    chk("reset rd_rsp_ready", bus.rd_rsp_ready, 1'b0);
    chk("reset out_data_valid", bus.out_data_valid, 1'b0);
    chk("reset out_data", bus.out_data, '0);
    chk("reset credit_err", bus.credit_err, 1'b0);
    @(posedge clk); #1;
    idle_inputs();
    rst = 1'b1;
    model_reset();
  endtask

  localparam logic [RW-1:0] C_FIN_PKT  = 36'hF_FFFF_0001;
  localparam logic [RW-1:0] C_DONE_PKT = 36'h2_0005_00AB;

  initial begin
    int g;
    int ngr;
    bit fin_pend;
    logic [63:0] r;
    logic [RW-1:0] prd, poa;

    // rd oa fin st cr expected-grant
    tbl.push_back(v(1,0,0,0,0,G_RD));   // 0  credit exhaustion
    tbl.push_back(v(1,0,0,0,0,G_RD));
    tbl.push_back(v(1,0,0,0,0,G_RD));
    tbl.push_back(v(1,0,0,0,0,G_RD));   // 3  cnt -> 0
    tbl.push_back(v(1,0,0,0,0,G_NONE));
    tbl.push_back(v(1,0,0,0,1,G_NONE)); // 5  credit at zero: no same-cycle grant
    tbl.push_back(v(1,0,0,0,0,G_RD));   // 6  one packet, 2 cycles after pulse
    tbl.push_back(v(1,0,0,0,0,G_NONE));
    tbl.push_back(v(1,1,0,0,1,G_NONE)); // 8  round-robin with returning credit
    tbl.push_back(v(1,1,0,0,1,G_OA));
    tbl.push_back(v(1,1,0,0,1,G_RD));
    tbl.push_back(v(1,1,0,0,1,G_OA));
    tbl.push_back(v(1,1,0,0,1,G_RD));
    tbl.push_back(v(0,0,0,0,1,G_NONE)); // 13 cnt -> 2
    tbl.push_back(v(1,0,0,0,1,G_RD));   // 14 grant+credit at 2 -> stays 2
    tbl.push_back(v(0,0,0,0,1,G_NONE));
    tbl.push_back(v(0,0,0,0,1,G_NONE)); // 16 cnt -> 4
    tbl.push_back(v(0,0,0,0,1,G_NONE)); // 17 overflow -> credit_err
    tbl.push_back(v(0,0,0,0,0,G_NONE));
    tbl.push_back(v(0,1,0,0,0,G_OA));   // 19 count still 4: four grants
    tbl.push_back(v(1,1,0,0,0,G_RD));
    tbl.push_back(v(1,1,0,0,0,G_OA));
    tbl.push_back(v(1,1,0,0,0,G_RD));
    tbl.push_back(v(1,1,0,0,0,G_NONE));
    tbl.push_back(v(0,0,0,0,1,G_NONE)); // 24 refill
    tbl.push_back(v(0,0,0,0,1,G_NONE));
    tbl.push_back(v(0,0,0,0,1,G_NONE));
    tbl.push_back(v(0,0,0,0,1,G_NONE));
    tbl.push_back(v(0,1,1,0,0,G_OA));   // 28 fin rises, 2 oact pending
    tbl.push_back(v(0,1,1,0,0,G_OA));
    tbl.push_back(v(0,0,1,0,0,G_FIN));  // 30 fin after last oact
    tbl.push_back(v(0,1,1,0,0,G_NONE)); // 31 DONE: oact blocked, fin ignored
    tbl.push_back(v(1,1,0,0,0,G_RD));   // 32 DONE: rd still served
    tbl.push_back(v(0,1,0,1,1,G_NONE)); // 33 start -> RUN
    tbl.push_back(v(0,1,0,0,0,G_OA));   // 34 oact served again
    tbl.push_back(v(0,0,0,0,1,G_NONE));

    do_reset();
    foreach (tbl[i]) begin
      prd = 36'h1_0000_0000 + 36'(i);
      poa = 36'h3_0000_0000 + 36'(i);
      cyc(tbl[i].rd, tbl[i].oa, tbl[i].fin, tbl[i].st, tbl[i].cr, prd, poa, C_FIN_PKT, g);
      chk($sformatf("tbl[%0d] grant", i), 64'(g), 64'(tbl[i].exp_g));
    end
    chk("credit_err sticky", bus.credit_err, 1'b1);

    // Fresh reset: rd wins the first tie, then strict alternation
    do_reset();
    chk("credit_err cleared by reset", bus.credit_err, 1'b0);
    for (int k = 0; k < 6; k++) begin
      cyc(1, 1, 0, 0, 1, 36'h1_0000_0100 + 36'(k), 36'h3_0000_0100 + 36'(k), C_FIN_PKT, g);
      chk($sformatf("rr[%0d] grant", k), 64'(g), 64'((k % 2 == 0) ? G_RD : G_OA));
    end

    // DONE: rd packet emitted one cycle after grant, oact waits for start
    do_reset();
    cyc(0, 0, 1, 0, 0, '0, '0, C_FIN_PKT, g);
    cyc(0, 0, 1, 0, 0, '0, '0, C_FIN_PKT, g);
    chk("done fin grant", 64'(g), 64'(G_FIN));
    cyc(0, 1, 0, 0, 0, '0, 36'h3_0000_0200, C_FIN_PKT, g);
    chk("done oact blocked", 64'(g), 64'(G_NONE));
    cyc(1, 0, 0, 0, 0, C_DONE_PKT, '0, C_FIN_PKT, g);
    chk("done rd grant", 64'(g), 64'(G_RD));
    chk("done rd out valid", bus.out_data_valid, 1'b1);
    chk("done rd out data", bus.out_data, C_DONE_PKT);
    cyc(0, 1, 0, 1, 0, '0, 36'h3_0000_0201, C_FIN_PKT, g);
    chk("start cycle oact", 64'(g), 64'(G_NONE));
    cyc(0, 1, 0, 0, 0, '0, 36'h3_0000_0201, C_FIN_PKT, g);
    chk("oact after start", 64'(g), 64'(G_OA));

    // Asynchronous reset between edges during a burst
    cyc(1, 0, 0, 0, 0, 36'h1_0000_0300, '0, C_FIN_PKT, g);
    chk("burst out valid", bus.out_data_valid, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("async rst out_data_valid", bus.out_data_valid, 1'b0);
    chk("async rst rd_rsp_ready", bus.rd_rsp_ready, 1'b0);
    @(posedge clk); #1;
    idle_inputs();
    rst = 1'b1;
    model_reset();
    ngr = 0;
    for (int k = 0; k < 6; k++) begin
      cyc(1, 0, 0, 0, 0, 36'h1_0000_0400 + 36'(k), '0, C_FIN_PKT, g);
      if (g != G_NONE) ngr++;
    end
    chk("grants after async reset", 64'(ngr), 64'(DEPTH));

    // Random traffic against the model
    do_reset();
    fin_pend = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      bit rd, oa, fin, st, cr;
      if (!fin_pend && m_phase == PH_RUN && $urandom_range(0, 19) == 0) fin_pend = 1'b1;
      rd  = ($urandom_range(0, 2) == 0);
      oa  = ($urandom_range(0, 1) == 0);
      cr  = ($urandom_range(0, 2) == 0);
      st  = ($urandom_range(0, 15) == 0);
      fin = fin_pend || (m_phase == PH_DONE && $urandom_range(0, 3) == 0);
      r   = {$urandom(), $urandom()};
      prd = r[RW-1:0];
      r   = {$urandom(), $urandom()};
      poa = r[RW-1:0];
      cyc(rd, oa, fin, st, cr, prd, poa, C_FIN_PKT, g);
      if (g == G_FIN) fin_pend = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
